// File: rtl/skew_tile_buffer_pkg.sv
// skew_tile_buffer_pkg: shared defaults, FSM encoding and clog2.
// Ports: none (package only).
package skew_tile_buffer_pkg;

  localparam int DSP_DELAY = 4;
  localparam int DATA_W_D  = 8;
  localparam int LANES_D   = 4;
  localparam int DEPTH_D   = 8;
  localparam int SKEW_D    = DSP_DELAY - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/skew_tile_buffer_if.sv
// skew_tile_buffer_if: input vector handshake and per-lane outputs.
// Ports: in_valid/in_ready/in_data, out_valid/out_data; master/slave.
interface skew_tile_buffer_if
  import skew_tile_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int LANES  = LANES_D
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        out_valid;
  logic [LANES*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/skew_tile_buffer_mem.sv
// tile_vector_mem: DEPTH x vector regfile, one write, per-lane reads.
// Ports: clk, we/waddr/wdata, raddr (per lane), rdata (per lane).
module tile_vector_mem
  import skew_tile_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int LANES  = LANES_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int AW     = 3
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [LANES*DATA_W-1:0] wdata,
  input  logic [LANES*AW-1:0]     raddr,
  output logic [LANES*DATA_W-1:0] rdata
);

  logic [LANES*DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      rdata[i*DATA_W +: DATA_W] =
        mem[raddr[i*AW +: AW]][i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/skew_tile_buffer.sv
// skew_tile_buffer: stores a tile, drains it with per-lane diagonal skew.
// Ports: clk, rst_n, clear, start, stall, busy, done, bus (slave).
module skew_tile_buffer
  import skew_tile_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int LANES  = LANES_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int SKEW   = SKEW_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  skew_tile_buffer_if.slave bus
);

  localparam int LAST = (LANES - 1) * SKEW;
  localparam int CW   = clog2(DEPTH + 1);
  localparam int TW0  = clog2(DEPTH + LAST);
  localparam int TW   = TW0 > 0 ? TW0 : 1;
  localparam int AW   = DEPTH > 1 ? clog2(DEPTH) : 1;
  localparam int VW   = LANES * DATA_W;

  state_t            state, state_n;
  logic [CW-1:0]     wr_cnt, wr_cnt_n;
  logic [CW-1:0]     len, len_n;
  logic [TW-1:0]     t, t_n;
  logic              done_n;
  logic [LANES-1:0]  ov, ov_n, lane_v;
  logic [VW-1:0]     od, od_n, rdata;
  logic [LANES*AW-1:0] raddr;
  logic              acc, we, last;

  // busy spans the done cycle so the last lane word is still "in drain"
  assign busy = (state == DRAIN) || done;
  assign bus.in_ready = (state == IDLE) && !done
                     && (wr_cnt < CW'(DEPTH));
  assign acc  = bus.in_valid && bus.in_ready;
  assign we   = acc && !clear;
  assign last = int'(t) == int'(len) + LAST - 1;

  assign bus.out_valid = ov;
  assign bus.out_data  = od;

  tile_vector_mem #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // lane i sees word t-i*SKEW while that index lies inside the tile
  always_comb begin
    lane_v = '0;
    raddr  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (int'(t) >= i*SKEW &&
          int'(t) < i*SKEW + int'(len)) begin
        lane_v[i] = 1'b1;
        raddr[i*AW +: AW] = AW'(int'(t) - i*SKEW);
      end
    end
  end

  always_comb begin
    state_n  = state;
    wr_cnt_n = wr_cnt;
    len_n    = len;
    t_n      = t;
    done_n   = 1'b0;
    ov_n     = ov;
    od_n     = od;
    unique case (state)
      IDLE: begin
        ov_n = '0;
        od_n = '0;
        if (acc) wr_cnt_n = wr_cnt + CW'(1);
        if (start && (wr_cnt != '0 || acc)) begin
          state_n = DRAIN;
          len_n   = wr_cnt + CW'(acc);
          t_n     = '0;
        end
      end
      DRAIN: begin
        if (!stall) begin
          ov_n = lane_v;
          for (int i = 0; i < LANES; i++) begin
            od_n[i*DATA_W +: DATA_W] = lane_v[i]
              ? rdata[i*DATA_W +: DATA_W] : '0;
          end
          t_n = t + TW'(1);
          if (last) begin
            done_n   = 1'b1;
            wr_cnt_n = '0;
            t_n      = '0;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_cnt <= '0;
      len    <= '0;
      t      <= '0;
      done   <= 1'b0;
      ov     <= '0;
      od     <= '0;
    end else if (clear) begin
      state  <= IDLE;
      wr_cnt <= '0;
      len    <= '0;
      t      <= '0;
      done   <= 1'b0;
      ov     <= '0;
      od     <= '0;
    end else begin
      state  <= state_n;
      wr_cnt <= wr_cnt_n;
      len    <= len_n;
      t      <= t_n;
      done   <= done_n;
      ov     <= ov_n;
      od     <= od_n;
    end
  end

endmodule

// File: tb/tb_skew_tile_buffer.sv
// tb_skew_tile_buffer: scoreboard bench for skew_tile_buffer.
// Stimulus queues expected lane words/done; a negedge monitor checks.
module tb_skew_tile_buffer;
  import skew_tile_buffer_pkg::*;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int S  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic busy, done;

  skew_tile_buffer_if #(.DATA_W(DW), .LANES(L)) bus ();

  skew_tile_buffer #(
    .DATA_W (DW),
    .LANES  (L),
    .DEPTH  (D),
    .SKEW   (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .start (start),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             c;
    logic [DW-1:0]  d;
  } exp_t;

  exp_t        lq [L][$];
  int          dq [$];
  logic [31:0] model [$];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int e0     = 0;
  int dcyc   = 0;
  bit mon_en = 1'b0;
  logic held = 1'b0;
  logic [L-1:0]    prev_v = '0;
  logic [L*DW-1:0] prev_d = '0;

  always @(posedge clk) begin
    cyc++;
    held <= stall;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cyc %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
  endtask

  function automatic logic [31:0] vec(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < L; i++) v[i*DW +: DW] = 8'(16*k + i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < L; i++) lq[i].delete();
    dq.delete();
  endtask

  // monitor: pops one expected word per valid lane per fresh cycle
  exp_t x;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (held) begin
        chk("hold_valid", bus.out_valid, prev_v);
        chk("hold_data", bus.out_data, prev_d);
        chk("hold_no_done", done, 1'b0);
      end else begin
        for (int i = 0; i < L; i++) begin
          if (bus.out_valid[i]) begin
            if (lq[i].size() == 0) begin
              chk($sformatf("lane%0d_unexp", i), bus.out_valid[i], 1'b0);
            end else begin
              x = lq[i].pop_front();
              chk($sformatf("lane%0d_cyc", i), cyc, x.c);
              chk($sformatf("lane%0d_data", i),
                  bus.out_data[i*DW +: DW], x.d);
            end
          end else begin
            chk($sformatf("lane%0d_zero", i),
                bus.out_data[i*DW +: DW], '0);
          end
        end
        if (done) begin
          if (dq.size() == 0) chk("done_unexp", done, 1'b0);
          else chk("done_cyc", cyc, dq.pop_front());
        end
      end
    end
    prev_v = bus.out_valid;
    prev_d = bus.out_data;
  end

  task automatic load(input int k);
    bus.in_valid = 1'b1;
    bus.in_data  = vec(k);
    chk("in_ready", bus.in_ready, model.size() < D);
    if (model.size() < D) model.push_back(vec(k));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic issue_start(input bit acc, input int k);
    start = 1'b1;
    if (acc) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec(k);
      chk("in_ready_acc", bus.in_ready, 1'b1);
      model.push_back(vec(k));
    end
    step();
    start = 1'b0;
    bus.in_valid = 1'b0;
    e0 = cyc;
  endtask

  // word k of lane i leaves at relative edge 1+i*S+k, shifted by stalls
  task automatic expect_drain(input int s_at, input int s_n);
    int   n;
    int   e;
    exp_t w;
    n = model.size();
    for (int i = 0; i < L; i++) begin
      for (int k = 0; k < n; k++) begin
        e = 1 + i*S + k;
        if (s_n > 0 && e >= s_at) e += s_n;
        w.c = e0 + e;
        w.d = model[k][i*DW +: DW];
        lq[i].push_back(w);
      end
    end
    dcyc = 1 + n + (L-1)*S + s_n;
    dq.push_back(e0 + dcyc - 1);
    model.delete();
  endtask

  task automatic follow(input int s_at, input int s_n, input int poke);
    for (int c = 1; c <= dcyc + 1; c++) begin
      stall = (s_n > 0 && c >= s_at && c < s_at + s_n);
      start = (c == poke);
      chk("busy", busy, c <= dcyc);
      chk("in_ready_drain", bus.in_ready, c > dcyc);
      step();
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, bus.out_valid, '0);
    chk({nm, "_data"}, bus.out_data, '0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // reset mid-cycle, then idle
    #3 rst_n = 1'b0;
    #1 chk_idle("rst");
    step();
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) begin
      step();
      chk_idle("idle");
    end

    // 4-vector tile
    for (int k = 0; k < 4; k++) load(k);
    issue_start(1'b0, 0);
    expect_drain(0, 0);
    follow(0, 0, 0);

    // fill: 9th vector refused
    for (int k = 0; k < 9; k++) load(k);
    issue_start(1'b0, 0);
    expect_drain(0, 0);
    follow(0, 0, 0);

    // stall 3 cycles mid lane1
    for (int k = 0; k < 4; k++) load(k + 2);
    issue_start(1'b0, 0);
    expect_drain(6, 3);
    follow(6, 3, 0);

    // start on empty buffer
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) begin
      chk_idle("empty");
      step();
    end

    // accept+start, plus start poked mid drain
    load(5);
    issue_start(1'b1, 6);
    expect_drain(0, 0);
    follow(0, 0, 4);

    // async reset mid drain
    for (int k = 1; k < 4; k++) load(k);
    issue_start(1'b0, 0);
    expect_drain(0, 0);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1 chk_idle("abort_rst");
    flush();
    step();
    rst_n = 1'b1;
    step();

    // sync clear mid drain, then 1-vector tile
    load(4);
    load(5);
    issue_start(1'b0, 0);
    expect_drain(0, 0);
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_idle("clear");
    flush();
    step();
    load(7);
    issue_start(1'b0, 0);
    expect_drain(0, 0);
    follow(0, 0, 0);

    repeat (3) step();
    for (int i = 0; i < L; i++)
      chk($sformatf("lane%0d_left", i), lq[i].size(), 0);
    chk("done_left", dq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/skew_tile_buffer.md
Name: skew_tile_buffer

Overview:
- Parametrised, multi-lane successor to the per-lane input shift register feeding the systolic array edge.
- Buffers up to DEPTH input vectors, each LANES words wide, accepted one vector per cycle over a valid/ready handshake.
- On a start command it drains the tile with a programmable diagonal skew: lane i lags lane 0 by i*SKEW cycles. Idle slots are zero-filled.
- Adds what the old block lacked: backpressure, global stall, variable tile length, busy/done status and synchronous clear.

Parameters:
- DATA_W, 8, width of one data word.
- LANES, 4, number of array rows/columns fed (parallel output lanes).
- DEPTH, 8, maximum vectors per tile; must be >= 1.
- SKEW, 3, per-lane lag in cycles (DSP pipeline delay minus 1); 0 is legal and means no skew.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort/flush.
- in_valid  in  1  input vector valid.
- in_ready  out  1  buffer can accept a vector.
- in_data  in  LANES*DATA_W  input vector; lane i at bits [i*DATA_W +: DATA_W].
- start  in  1  begin draining the stored tile.
- stall  in  1  freeze drain (array-wide hold).
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse, aligned with the last valid word of lane LANES-1.
- out_valid  out  LANES  per-lane word valid.
- out_data  out  LANES*DATA_W  per-lane word; 0 when the lane is not valid.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; wr_cnt=0; t=0; in_ready=1, busy=0, done=0, out_valid=0, out_data=0. Memory contents are not reset.
- clear (sync, highest priority after reset): same register values as reset, effective at the next edge; memory is untouched.
- FSM has two states, IDLE and DRAIN.
- IDLE:
  - in_ready = (wr_cnt < DEPTH).
  - On in_valid && in_ready: mem[wr_cnt] <= in_data; wr_cnt++.
  - start with (wr_cnt>0 or accept this cycle): go to DRAIN, len <= wr_cnt + accept, t <= 0.
  - start with an empty buffer and no accept: ignored, no done pulse.
- DRAIN:
  - in_ready=0; start is ignored; busy=1.
  - Each non-stalled cycle, output registers load: lane i valid iff i*SKEW <= t < i*SKEW+len. Data is mem[t-i*SKEW] lane i when valid, else 0.
  - Then t++.
  - When t == len-1+(LANES-1)*SKEW is processed: done register set, wr_cnt <= 0, go to IDLE.
- stall=1 in DRAIN: t, state, out_valid and out_data hold their values; done is not asserted while stalled. stall is ignored in IDLE.
- Latency and timing:
  - start sampled at edge 0; output word k of lane i is visible in cycle 2+i*SKEW+k.
  - busy is high cycles 1 .. final; done is high in cycle 1+len+(LANES-1)*SKEW, assuming no stalls.
  - Total drain: len+(LANES-1)*SKEW cycles.
- Outputs after drain: cycle after done, out_valid and out_data return to 0 and in_ready returns to 1.
- Widths: wr_cnt and len are clog2(DEPTH+1) bits; t is clog2(DEPTH+(LANES-1)*SKEW) bits. No arithmetic is performed on data.

Decomposition:
- Shared package holds:
  - DATA_W, LANES and SKEW defaults, with SKEW derived from the DSP delay constant.
  - The state encoding (IDLE=0, DRAIN=1).
  - A clog2 function.
- One natural sub-module, tile_vector_mem: a DEPTH x (LANES*DATA_W) register file with one full-vector write port and LANES independent per-lane read ports.

Test Plan:
All scenarios use default parameters.
1. Reset: rst_n low mid-cycle -> all outputs 0 immediately and in_ready=1; release, then idle 5 cycles -> nothing changes.
2. Load 4 vectors (lane i of vector k = 0x10*k+i), then start:
   - lane0 valid in cycles 2-5 with 0x00, 0x10, 0x20, 0x30;
   - lane3 valid in cycles 11-14 with 0x03 .. 0x33;
   - done in cycle 14 only; busy cycles 1-14.
3. Fill: 9 back-to-back valid vectors -> in_ready falls after the 8th; the 9th is held off. Drain -> len=8, done in cycle 18.
4. stall high for 3 cycles while lane1 is mid-word -> all lanes hold their values; done moves from cycle 14 to cycle 17.
5. Edge handshakes:
   - start on an empty buffer -> no busy/done;
   - accept+start in the same cycle with 1 stored -> len=2;
   - start during DRAIN -> ignored.
6. Abort mid-drain:
   - rst_n low -> outputs 0 asynchronously;
   - separately, clear -> IDLE next cycle with wr_cnt=0; a new 1-vector tile then drains correctly.
